// File: rtl/sram_spi_arbiter.sv
// Round-robin arbiter and command sequencer sharing one SPI SRAM engine between two requesters.
// Runs a one-shot mode-register write after reset, then issues single-cycle instruction pulses.
module sram_spi_arbiter #(
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned LEN_W     = 24,
    parameter logic [7:0]  INIT_MODE = 8'h40,
    parameter bit          DO_INIT   = 1'b1,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [7:0]        r0_wdata,
    input  logic [LEN_W-1:0]  r0_len,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [7:0]        r1_wdata,
    input  logic [LEN_W-1:0]  r1_len,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic              r1_err,
    output logic [7:0]        eng_inst,
    output logic [ADDR_W-1:0] eng_addr,
    output logic [7:0]        eng_wdata,
    output logic [LEN_W-1:0]  eng_len,
    input  logic              eng_busy,
    input  logic              eng_done,
    output logic              init_done
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [7:0] INST_NONE  = 8'd0;
    localparam logic [7:0] INST_WRSR  = 8'd1;
    localparam logic [7:0] INST_WRITE = 8'd2;
    localparam logic [7:0] INST_READ  = 8'd3;

    typedef enum logic [2:0] {
        StInitIssue,
        StInitWait,
        StIdle,
        StIssue,
        StBusy
    } state_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             prio;     // 1: r1 wins a tie
    logic             sel;      // requester owning the current transaction

    logic              pick_r1;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [7:0]        pick_wdata;
    logic [LEN_W-1:0]  pick_len;

    always_comb begin
        pick_r1    = r1_req && (!r0_req || prio);
        pick_we    = pick_r1 ? r1_we    : r0_we;
        pick_addr  = pick_r1 ? r1_addr  : r0_addr;
        pick_wdata = pick_r1 ? r1_wdata : r0_wdata;
        pick_len   = pick_r1 ? r1_len   : r0_len;
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state     <= DO_INIT ? StInitIssue : StIdle;
            cnt       <= '0;
            prio      <= 1'b0;
            sel       <= 1'b0;
            r0_gnt    <= 1'b0;
            r0_done   <= 1'b0;
            r0_err    <= 1'b0;
            r1_gnt    <= 1'b0;
            r1_done   <= 1'b0;
            r1_err    <= 1'b0;
            eng_inst  <= INST_NONE;
            eng_addr  <= '0;
            eng_wdata <= '0;
            eng_len   <= '0;
            init_done <= 1'b0;
        end else begin
            // Pulse outputs default low; eng_inst is never held past one cycle.
            r0_gnt   <= 1'b0;
            r1_gnt   <= 1'b0;
            r0_done  <= 1'b0;
            r1_done  <= 1'b0;
            r0_err   <= 1'b0;
            r1_err   <= 1'b0;
            eng_inst <= INST_NONE;
            case (state)
                StInitIssue: begin
                    if (!eng_busy) begin
                        eng_inst  <= INST_WRSR;
                        eng_addr  <= '0;
                        eng_wdata <= INIT_MODE;
                        eng_len   <= '0;
                        cnt       <= '0;
                        state     <= StInitWait;
                    end
                end
                StInitWait: begin
                    if (eng_done) begin
                        init_done <= 1'b1;
                        cnt       <= '0;
                        state     <= StIdle;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= StInitIssue;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StIdle: begin
                    // Covers DO_INIT = 0, where no init write ever completes.
                    init_done <= 1'b1;
                    cnt       <= '0;
                    if (init_done && !eng_busy && (r0_req || r1_req)) begin
                        sel       <= pick_r1;
                        eng_addr  <= pick_addr;
                        eng_wdata <= pick_wdata;
                        eng_len   <= pick_len;
                        eng_inst  <= pick_we ? INST_WRITE : INST_READ;
                        r0_gnt    <= !pick_r1;
                        r1_gnt    <= pick_r1;
                        state     <= StIssue;
                    end
                end
                StIssue: begin
                    state <= StBusy;
                end
                StBusy: begin
                    // eng_done wins over a simultaneous timeout.
                    if (eng_done || cnt == CNT_LAST) begin
                        r0_done <= !sel;
                        r1_done <= sel;
                        r0_err  <= !sel && !eng_done;
                        r1_err  <= sel && !eng_done;
                        prio    <= !sel;
                        cnt     <= '0;
                        state   <= StIdle;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_spi_arbiter.md
Name: sram_spi_arbiter

Overview:
Two-requester arbiter and sequencer for the SPI SRAM read/write engine on the DE10-Lite accelerator. It shares one SPI engine between requester 0 (Raspberry Pi host bridge) and requester 1 (accelerator datapath). After reset it configures the SRAM mode register once. It then grants transactions round-robin, presents each command to the engine as a single-cycle instruction pulse, and returns a per-requester done or error pulse.

Parameters:
ADDR_W, 24, SRAM address width.
LEN_W, 24, transfer length field width, passed through to the engine unchanged.
INIT_MODE, 8'h40, byte written to the SRAM status/mode register at init (sequential mode).
DO_INIT, 1, 1 runs the init write after reset; 0 goes straight to IDLE.
TIMEOUT, 4096, maximum BUSY cycles before a transaction is aborted; must be at least 2.

Ports:
sclk  in  1  system clock; all logic on posedge.
reset  in  1  synchronous, active-high reset.
r0_req  in  1  requester 0 transaction request (level).
r0_we  in  1  requester 0: 1 = write (inst 2), 0 = read (inst 3).
r0_addr  in  ADDR_W  requester 0 address.
r0_wdata  in  8  requester 0 write byte.
r0_len  in  LEN_W  requester 0 length.
r0_gnt  out  1  one-cycle pulse: requester 0 command captured.
r0_done  out  1  one-cycle pulse: requester 0 transaction finished.
r0_err  out  1  one-cycle pulse, coincident with r0_done, on timeout.
r1_req, r1_we, r1_addr, r1_wdata, r1_len, r1_gnt, r1_done, r1_err  same as r0_*, for requester 1.
eng_inst  out  8  engine instruction: 0 = none, 1 = WRSR, 2 = WRITE, 3 = READ.
eng_addr  out  ADDR_W  engine address.
eng_wdata  out  8  engine write byte.
eng_len  out  LEN_W  engine length.
eng_busy  in  1  engine not in its wait state.
eng_done  in  1  engine one-cycle completion pulse.
init_done  out  1  high once the mode init write has completed (or immediately if DO_INIT = 0).

Behaviour:
- Reset values: all outputs 0. State is INIT_ISSUE if DO_INIT = 1, otherwise IDLE. Priority pointer = r0 first; timeout counter = 0. Reset mid-transaction abandons it without a done pulse and re-runs init.
- States: INIT_ISSUE, INIT_WAIT, IDLE, ISSUE, BUSY.
- INIT_ISSUE:
  - Waits for eng_busy = 0.
  - For one cycle drives eng_inst = 1, eng_addr = 0, eng_wdata = INIT_MODE, eng_len = 0.
  - Then goes to INIT_WAIT.
- INIT_WAIT:
  - On eng_done: init_done <= 1 and go to IDLE.
  - On timeout: retry from INIT_ISSUE (no requester pulses).
- IDLE (init_done = 1, eng_busy = 0):
  - Only r0_req: select r0. Only r1_req: select r1.
  - Both: select the requester not served last. Pointer after reset favours r0.
  - On selection: latch that requester's we/addr/wdata/len into the eng_* registers, go to ISSUE.
- ISSUE (exactly one cycle):
  - eng_inst = 2 or 3 per latched we; rX_gnt = 1.
  - Next cycle: eng_inst returns to 0 and state is BUSY.
  - eng_inst must never be nonzero for more than one cycle, otherwise the engine re-triggers.
- BUSY:
  - eng_addr, eng_wdata and eng_len hold their latched values.
  - The timeout counter increments each cycle.
  - On eng_done: rX_done pulses the next cycle, pointer <= X, counter cleared, go to IDLE.
  - If the counter reaches TIMEOUT - 1 without eng_done: rX_done and rX_err pulse together, then go to IDLE.
  - eng_done and timeout on the same cycle: treated as done, no error.
- Latency: req sampled in IDLE at edge t -> gnt and eng_inst visible in cycle t+1. eng_done at edge t -> rX_done in cycle t+1. There is at least one IDLE cycle between transactions.
- Requesters may drop req after gnt. A req raised while the other requester is BUSY waits. A req that drops before grant is ignored.
- eng_done outside INIT_WAIT/BUSY is ignored.
- The length field is passed through with no arithmetic.

Test Plan:
1. Reset with DO_INIT = 1, engine model pulses done 40 cycles after inst -> one eng_inst = 1 pulse with eng_wdata = 8'h40, addr 0; init_done rises; no rX_gnt before it.
2. r0 read, addr 24'h00_1234, len 0 -> eng_inst = 3 for exactly one cycle with r0_gnt; eng_addr stable until done; r0_done one cycle after eng_done; r0_err = 0.
3. r0 and r1 both request continuously, writes wdata 8'hA5 / 8'h5A -> grants alternate r0, r1, r0, r1; each eng_inst = 2 carries the matching wdata.
4. Engine model never returns done, TIMEOUT = 16 -> r1_done and r1_err pulse together 16 BUSY cycles after issue; state back to IDLE; next r0 request is served.
5. Assert reset during BUSY -> all outputs 0 next cycle; no done pulse for the aborted transaction; init write re-issued.
6. r1_req rises in the same cycle r0's eng_done arrives -> r0_done pulses, then r1_gnt follows after one IDLE cycle.
